// File: rtl/bram_pkg.sv
// ---------------------------------------------------------------------------
// bram_pkg
//
// Shared definitions for the 32-word x 32-bit scratch memory and the
// two-port arbiter that fronts it.
//
//   BRAM_AW / BRAM_DW : word-address width and data width of the scratch RAM
//   PORT_CPU/PORT_AUX : port identifiers (CPU data port = 0, aux master = 1)
//   tag_t             : response tag carried alongside an issued command
// ---------------------------------------------------------------------------
package bram_pkg;

    localparam int BRAM_AW = 5;
    localparam int BRAM_DW = 32;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    // One tag per issued memory command. 'read' separates commands that
    // return data from writes, 'port' routes the returned data.
    typedef struct packed {
        logic valid;
        logic read;
        logic port;
    } tag_t;

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
//
// Two-requester grant generator. Round-robin by default; with PRIO_FIXED
// set, requester 0 always wins a contention.
//
// Ports:
//   clk     : rising-edge clock
//   resetn  : asynchronous active-low reset
//   req[1:0]: request lines, bit i = requester i
//   gnt[1:0]: one-hot grant, combinational from req and the last-grant state
// ---------------------------------------------------------------------------
module rr_arb2
    import bram_pkg::*;
#(
    parameter int PRIO_FIXED = 0
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // Id of the port granted most recently. Resets to the aux port so the
    // CPU port wins the first contention after reset.
    logic last;

    // A lone requester always wins. Under contention the port that was not
    // served last wins, unless fixed priority hands it to port 0.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01: gnt = 2'b01;
            2'b10: gnt = 2'b10;
            2'b11: begin
                if (PRIO_FIXED != 0 || last == PORT_AUX) begin
                    gnt = 2'b01;
                end else begin
                    gnt = 2'b10;
                end
            end
            default: gnt = 2'b00;
        endcase
    end

    // Remember who was served; idle cycles leave the history untouched.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last <= PORT_AUX;
        end else if (gnt != 2'b00) begin
            last <= gnt[1];
        end
    end

endmodule

// File: rtl/bram_arbiter.sv
// ---------------------------------------------------------------------------
// bram_arbiter
//
// Shares the single-ported scratch RAM between the CPU data port (port 0)
// and an auxiliary master (port 1). One request is accepted per cycle, the
// winner's command is registered onto the memory interface the next cycle,
// and read data comes back to the issuing port two cycles after the grant.
//
// Parameters:
//   PRIO_FIXED : 0 = round-robin, 1 = port 0 always wins
//   AW, DW     : word-address width and data width
//
// Ports:
//   clk, resetn                  : clock, asynchronous active-low reset
//   pX_req/we/addr/wdata         : request from port X, held until granted
//   pX_gnt                       : combinational accept for port X
//   pX_rvalid, pX_rdata          : read return for port X
//   mem_cs/rd/wr/addr/wdata      : registered command to the RAM
//   mem_rdata                    : RAM read data, one cycle after cs&rd
// ---------------------------------------------------------------------------
module bram_arbiter
    import bram_pkg::*;
#(
    parameter int PRIO_FIXED = 0,
    parameter int AW         = BRAM_AW,
    parameter int DW         = BRAM_DW
) (
    input  logic          clk,
    input  logic          resetn,

    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW+1:2] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,

    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW+1:2] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,

    output logic          mem_cs,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW+1:2] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    logic [1:0]    gnt;
    logic          sel_we;
    logic [AW+1:2] sel_addr;
    logic [DW-1:0] sel_wdata;
    tag_t          tag_s1;
    tag_t          tag_s2;

    rr_arb2 #(
        .PRIO_FIXED (PRIO_FIXED)
    ) u_arb (
        .clk    (clk),
        .resetn (resetn),
        .req    ({p1_req, p0_req}),
        .gnt    (gnt)
    );

    assign p0_gnt = gnt[0];
    assign p1_gnt = gnt[1];

    // Steer the winning port's request toward the command registers. Port 0
    // is the default path; it only matters when some grant is active.
    always_comb begin
        sel_we    = p0_we;
        sel_addr  = p0_addr;
        sel_wdata = p0_wdata;
        if (gnt[1]) begin
            sel_we    = p1_we;
            sel_addr  = p1_addr;
            sel_wdata = p1_wdata;
        end
    end

    // Command registers plus the two-deep response tag pipeline. Address and
    // write data hold across idle cycles so the RAM inputs only toggle when a
    // new command is issued. Reset clears the tags, which drops any read
    // that is still in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_cs    <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            tag_s1    <= '0;
            tag_s2    <= '0;
        end else begin
            if (gnt != 2'b00) begin
                mem_cs    <= 1'b1;
                mem_rd    <= !sel_we;
                mem_wr    <= sel_we;
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
                tag_s1    <= '{valid: 1'b1, read: !sel_we, port: gnt[1]};
            end else begin
                mem_cs    <= 1'b0;
                mem_rd    <= 1'b0;
                mem_wr    <= 1'b0;
                tag_s1    <= '0;
            end
            tag_s2 <= tag_s1;
        end
    end

    // Stage 2 lines up with the cycle the RAM presents read data.
    assign p0_rvalid = tag_s2.valid && tag_s2.read && (tag_s2.port == PORT_CPU);
    assign p1_rvalid = tag_s2.valid && tag_s2.read && (tag_s2.port == PORT_AUX);

    assign p0_rdata = mem_rdata;
    assign p1_rdata = mem_rdata;

endmodule

// File: tb/tb_bram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bram_arbiter
//
// Drives the round-robin arbiter with directed sequences and random traffic
// against a simple RAM model, and compares every cycle with a transaction-
// level reference: each granted access happens atomically in grant order,
// its command appears one cycle later and its read data two cycles later.
// A second instance with fixed priority covers the priority mode.
// ---------------------------------------------------------------------------
module tb_bram_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk;
    logic          resetn;

    logic          p0_req, p0_we, p0_gnt, p0_rvalid;
    logic [AW+1:2] p0_addr;
    logic [DW-1:0] p0_wdata, p0_rdata;
    logic          p1_req, p1_we, p1_gnt, p1_rvalid;
    logic [AW+1:2] p1_addr;
    logic [DW-1:0] p1_wdata, p1_rdata;
    logic          mem_cs, mem_rd, mem_wr;
    logic [AW+1:2] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    logic          fx_p0_req, fx_p0_gnt, fx_p0_rvalid;
    logic          fx_p1_req, fx_p1_gnt, fx_p1_rvalid;
    logic [DW-1:0] fx_p0_rdata, fx_p1_rdata;
    logic          fx_cs, fx_rd, fx_wr;
    logic [AW+1:2] fx_addr;
    logic [DW-1:0] fx_wdata;

    int n_checks = 0;
    int n_errors = 0;

    bram_arbiter #(.PRIO_FIXED(0), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .p0_req    (p0_req),
        .p0_we     (p0_we),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_gnt    (p0_gnt),
        .p0_rvalid (p0_rvalid),
        .p0_rdata  (p0_rdata),
        .p1_req    (p1_req),
        .p1_we     (p1_we),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_gnt    (p1_gnt),
        .p1_rvalid (p1_rvalid),
        .p1_rdata  (p1_rdata),
        .mem_cs    (mem_cs),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    bram_arbiter #(.PRIO_FIXED(1), .AW(AW), .DW(DW)) dut_fix (
        .clk       (clk),
        .resetn    (resetn),
        .p0_req    (fx_p0_req),
        .p0_we     (1'b0),
        .p0_addr   (5'd1),
        .p0_wdata  (32'd0),
        .p0_gnt    (fx_p0_gnt),
        .p0_rvalid (fx_p0_rvalid),
        .p0_rdata  (fx_p0_rdata),
        .p1_req    (fx_p1_req),
        .p1_we     (1'b0),
        .p1_addr   (5'd2),
        .p1_wdata  (32'd0),
        .p1_gnt    (fx_p1_gnt),
        .p1_rvalid (fx_p1_rvalid),
        .p1_rdata  (fx_p1_rdata),
        .mem_cs    (fx_cs),
        .mem_rd    (fx_rd),
        .mem_wr    (fx_wr),
        .mem_addr  (fx_addr),
        .mem_wdata (fx_wdata),
        .mem_rdata (32'd0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM attached to the command port: writes at the edge the command is
    // visible, read data one cycle after a read command.
    logic [DW-1:0] bmem [0:31];
    always @(posedge clk) begin
        if (mem_cs && mem_wr) bmem[mem_addr] <= mem_wdata;
        if (mem_cs && mem_rd) mem_rdata <= bmem[mem_addr];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        int          port;
        logic [31:0] data;
        bit          known;
    } resp_t;

    resp_t       rq[$];
    logic [31:0] m_mem [0:31];
    bit          m_known [0:31];
    int          m_last = 1;
    int          cyc = 0;
    logic        e_cs = 0, e_rd = 0, e_wr = 0;
    logic [4:0]  e_addr = 0;
    logic [31:0] e_wdata = 0;

    always @(negedge clk) begin
        int    win;
        logic  ev0, ev1;
        logic  w_we;
        logic [4:0]  w_addr;
        logic [31:0] w_data;
        cyc++;
        if (!resetn) begin
            checkOutput("reset_cmd", {29'd0, mem_cs, mem_rd, mem_wr}, 32'd0);
            checkOutput("reset_addr", {27'd0, mem_addr}, 32'd0);
            checkOutput("reset_wdata", mem_wdata, 32'd0);
            checkOutput("reset_rvalid", {30'd0, p1_rvalid, p0_rvalid}, 32'd0);
            rq.delete();
            m_last  = 1;
            e_cs    = 0; e_rd = 0; e_wr = 0;
            e_addr  = 0; e_wdata = 0;
        end else begin
            // who must win this cycle
            if (p0_req && p1_req)  win = (m_last == 1) ? 0 : 1;
            else if (p0_req)       win = 0;
            else if (p1_req)       win = 1;
            else                   win = -1;
            checkOutput("gnt", {30'd0, p1_gnt, p0_gnt},
                        (win == 0) ? 32'd1 : (win == 1) ? 32'd2 : 32'd0);

            checkOutput("cmd", {29'd0, mem_cs, mem_rd, mem_wr}, {29'd0, e_cs, e_rd, e_wr});
            checkOutput("cmd_addr", {27'd0, mem_addr}, {27'd0, e_addr});
            checkOutput("cmd_wdata", mem_wdata, e_wdata);

            ev0 = 0; ev1 = 0;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                if (rq[0].port == 0) ev0 = 1; else ev1 = 1;
                if (rq[0].known)
                    checkOutput("rdata", (rq[0].port == 0) ? p0_rdata : p1_rdata, rq[0].data);
                void'(rq.pop_front());
            end
            checkOutput("p0_rvalid", {31'd0, p0_rvalid}, {31'd0, ev0});
            checkOutput("p1_rvalid", {31'd0, p1_rvalid}, {31'd0, ev1});

            // apply this cycle's access in grant order
            e_cs = 0; e_rd = 0; e_wr = 0;
            if (win >= 0) begin
                w_we   = (win == 0) ? p0_we : p1_we;
                w_addr = (win == 0) ? p0_addr : p1_addr;
                w_data = (win == 0) ? p0_wdata : p1_wdata;
                e_cs = 1; e_rd = !w_we; e_wr = w_we;
                e_addr = w_addr; e_wdata = w_data;
                if (w_we) begin
                    m_mem[w_addr]   = w_data;
                    m_known[w_addr] = 1;
                end else begin
                    rq.push_back('{due: cyc + 2, port: win,
                                   data: m_mem[w_addr], known: m_known[w_addr]});
                end
                m_last = win;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic applyStimulus(input logic r0, input logic we0, input logic [4:0] a0,
                                 input logic [31:0] d0, input logic r1, input logic we1,
                                 input logic [4:0] a1, input logic [31:0] d1);
        p0_req = r0; p0_we = we0; p0_addr = a0; p0_wdata = d0;
        p1_req = r1; p1_we = we1; p1_addr = a1; p1_wdata = d1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 5'd0, 32'd0, 0, 0, 5'd0, 32'd0);
    endtask

    initial begin
        logic g0, g1;
        for (int i = 0; i < 32; i++) m_known[i] = 0;
        resetn = 1'b0;
        idle();
        fx_p0_req = 1'b0;
        fx_p1_req = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        // single read after preload
        $display("[TB] single read");
        applyStimulus(1, 1, 5'd3, 32'hDEADBEEF, 0, 0, 5'd0, 32'd0);
        @(negedge clk); checkOutput("sr_wr_gnt", {31'd0, p0_gnt}, 32'd1);
        tick();
        applyStimulus(1, 0, 5'd3, 32'd0, 0, 0, 5'd0, 32'd0);
        @(negedge clk); checkOutput("sr_rd_gnt", {31'd0, p0_gnt}, 32'd1);
        tick(); idle();
        @(negedge clk);
        checkOutput("sr_cmd", {29'd0, mem_cs, mem_rd, mem_wr}, 32'd6);
        checkOutput("sr_addr", {27'd0, mem_addr}, 32'd3);
        tick();
        @(negedge clk);
        checkOutput("sr_rvalid", {31'd0, p0_rvalid}, 32'd1);
        checkOutput("sr_rdata", p0_rdata, 32'hDEADBEEF);
        checkOutput("sr_p1_quiet", {31'd0, p1_rvalid}, 32'd0);
        tick();

        // read-after-write across ports
        $display("[TB] read after write");
        applyStimulus(0, 0, 5'd0, 32'd0, 1, 1, 5'd31, 32'h12345678);
        @(negedge clk); checkOutput("raw_wr_gnt", {31'd0, p1_gnt}, 32'd1);
        tick();
        applyStimulus(1, 0, 5'd31, 32'd0, 0, 0, 5'd0, 32'd0);
        @(negedge clk); checkOutput("raw_rd_gnt", {31'd0, p0_gnt}, 32'd1);
        tick(); idle();
        tick();
        @(negedge clk);
        checkOutput("raw_rvalid", {31'd0, p0_rvalid}, 32'd1);
        checkOutput("raw_rdata", p0_rdata, 32'h12345678);
        tick();

        // address extremes
        $display("[TB] address wrap");
        applyStimulus(1, 1, 5'd31, 32'hA5A5A5A5, 0, 0, 5'd0, 32'd0); tick();
        applyStimulus(1, 1, 5'd0,  32'h5A5A5A5A, 0, 0, 5'd0, 32'd0); tick();
        applyStimulus(1, 0, 5'd31, 32'd0, 0, 0, 5'd0, 32'd0);        tick();
        applyStimulus(1, 0, 5'd0,  32'd0, 0, 0, 5'd0, 32'd0);        tick();
        idle();
        @(negedge clk); checkOutput("wrap_rd31", p0_rdata, 32'hA5A5A5A5);
        checkOutput("wrap_rv31", {31'd0, p0_rvalid}, 32'd1);
        tick();
        @(negedge clk); checkOutput("wrap_rd0", p0_rdata, 32'h5A5A5A5A);
        checkOutput("wrap_rv0", {31'd0, p0_rvalid}, 32'd1);
        tick();

        // fixed priority instance
        $display("[TB] fixed priority");
        fx_p0_req = 1'b1; fx_p1_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) fx_p0_req = 1'b0;
            @(negedge clk);
            checkOutput($sformatf("fix_gnt_%0d", i), {30'd0, fx_p1_gnt, fx_p0_gnt},
                        (i < 3) ? 32'd1 : 32'd2);
            tick();
        end
        fx_p1_req = 1'b0;

        // reset while a read is in flight
        $display("[TB] reset mid read");
        tick();
        applyStimulus(0, 0, 5'd0, 32'd0, 1, 0, 5'd3, 32'd0);
        @(negedge clk); checkOutput("rst_rd_gnt", {31'd0, p1_gnt}, 32'd1);
        tick(); idle();
        resetn = 1'b0;
        #1 checkOutput("rst_cs_async", {31'd0, mem_cs}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); checkOutput("rst_no_rvalid", {31'd0, p1_rvalid}, 32'd0);
            tick();
        end
        resetn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); checkOutput("post_rst_no_rvalid", {31'd0, p1_rvalid}, 32'd0);
            tick();
        end

        // continuous contention, starting from the post-reset history
        $display("[TB] round robin contention");
        applyStimulus(1, 0, 5'd5, 32'd0, 1, 0, 5'd6, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput($sformatf("rr_gnt_%0d", i), {30'd0, p1_gnt, p0_gnt},
                        (i % 2 == 0) ? 32'd1 : 32'd2);
            tick();
        end
        idle();
        tick();

        // random traffic; each port keeps its request until it sees a grant
        $display("[TB] random traffic");
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            g0 = p0_gnt; g1 = p1_gnt;
            @(posedge clk); #1;
            if (g0) p0_req = 1'b0;
            if (g1) p1_req = 1'b0;
            if (!p0_req && $urandom_range(0, 99) < 70) begin
                p0_req   = 1'b1;
                p0_we    = 1'($urandom_range(0, 1));
                p0_addr  = 5'($urandom_range(0, 7));
                p0_wdata = $urandom;
            end
            if (!p1_req && $urandom_range(0, 99) < 70) begin
                p1_req   = 1'b1;
                p1_we    = 1'($urandom_range(0, 1));
                p1_addr  = 5'($urandom_range(0, 7));
                p1_wdata = $urandom;
            end
        end
        @(negedge clk);
        @(posedge clk); #1;
        idle();
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
